// File: rtl/zap_wb_data_responder.sv
// rtl/zap_wb_data_responder.sv - Wishbone classic data-side responder backed by a word RAM with wait states
module zap_wb_data_responder #(
    parameter logic [31:0] DEPTH_WORDS = 32'd1024,
    parameter logic [31:0] WAIT_STATES = 32'd2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_dat,
    output logic        o_wb_ack,
    output logic        o_wb_err,
    output logic        o_busy
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam int          DEPTH = int'(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = {1'b0, DEPTH_WORDS} << 2;
    localparam logic [3:0]  WS    = WAIT_STATES[3:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [3:0]      wait_cnt;
    logic            req_we;
    logic            req_legal;
    logic [31:0]     req_dat;
    logic [3:0]      req_sel;
    logic [AW-1:0]   req_idx;

    logic [31:0]     mem [DEPTH];

    logic [31:0]     in_off;
    logic            in_legal;
    logic [AW-1:0]   in_idx;
    logic            new_req;
    logic            enter_resp;
    logic            rd_legal;
    logic            rd_we;
    logic [AW-1:0]   rd_idx;
    logic [31:0]     rd_word;

    assign in_off   = i_wb_adr - BASE_ADDR;
    assign in_legal = (i_wb_adr >= BASE_ADDR) && ({1'b0, in_off} < SPAN)
                      && (i_wb_adr[1:0] == 2'b00);
    assign in_idx   = in_off[AW+1:2];
    assign new_req  = (state == S_IDLE) && i_wb_cyc && i_wb_stb;

    // With zero wait states the response is formed straight from the bus inputs.
    assign enter_resp = (new_req && (WS == 4'd0))
                        || ((state == S_WAIT) && i_wb_cyc && (wait_cnt == 4'd1));
    assign rd_legal   = (state == S_IDLE) ? in_legal : req_legal;
    assign rd_we      = (state == S_IDLE) ? i_wb_we  : req_we;
    assign rd_idx     = (state == S_IDLE) ? in_idx   : req_idx;
    assign rd_word    = mem[rd_idx];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            req_we    <= 1'b0;
            req_legal <= 1'b0;
            req_dat   <= 32'd0;
            req_sel   <= 4'd0;
            req_idx   <= '0;
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_wb_dat  <= 32'd0;
            o_busy    <= 1'b0;
        end else begin
            o_wb_ack <= 1'b0;
            o_wb_err <= 1'b0;
            o_wb_dat <= 32'd0;
            case (state)
                S_IDLE: begin
                    if (new_req) begin
                        req_we    <= i_wb_we;
                        req_legal <= in_legal;
                        req_dat   <= i_wb_dat;
                        req_sel   <= i_wb_sel;
                        req_idx   <= in_idx;
                        wait_cnt  <= WS;
                        o_busy    <= 1'b1;
                        state     <= (WS != 4'd0) ? S_WAIT : S_RESP;
                    end
                end
                S_WAIT: begin
                    if (!i_wb_cyc) begin
                        state    <= S_IDLE;
                        wait_cnt <= 4'd0;
                        o_busy   <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                        if (wait_cnt == 4'd1) begin
                            state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
                default: begin
                    state  <= S_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
            if (enter_resp) begin
                o_wb_ack <= rd_legal;
                o_wb_err <= !rd_legal;
                o_wb_dat <= (rd_legal && !rd_we) ? rd_word : 32'd0;
            end
        end
    end

    // The write lands on the edge that closes the response cycle, so a reset there suppresses it.
    always_ff @(posedge i_clk) begin
        if (!i_reset && (state == S_RESP) && req_we && req_legal) begin
            for (int b = 0; b < 4; b++) begin
                if (req_sel[b]) begin
                    mem[req_idx][8*b +: 8] <= req_dat[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: doc/zap_wb_data_responder.md
Name: zap_wb_data_responder

Overview:
- Wishbone B3 classic responder (slave) for the ZAP data-side bus: accepts the cyc/stb/we/adr/dat/sel requests issued from the post-ALU stage.
- Backs a word-organised local data RAM with programmable wait states; returns ack with read data, or err for illegal accesses.
- Used as a tightly-coupled data memory and as the bench memory model for core-level regressions.

Parameters:
- DEPTH_WORDS, 32'd1024, number of 32-bit words in the RAM (power of two, >= 2).
- WAIT_STATES, 32'd2, idle cycles inserted between request acceptance and response (0..15).
- BASE_ADDR, 32'h0000_0000, byte address of word 0 (word aligned).

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  synchronous active-high reset.
- i_wb_cyc  input  1  bus cycle active.
- i_wb_stb  input  1  strobe, request valid.
- i_wb_we  input  1  1 = write, 0 = read.
- i_wb_adr  input  32  byte address.
- i_wb_dat  input  32  write data.
- i_wb_sel  input  4  byte lane enables; bit n covers dat[8n+7:8n].
- o_wb_dat  output  32  read data, valid only while o_wb_ack=1.
- o_wb_ack  output  1  normal termination, one-cycle pulse.
- o_wb_err  output  1  error termination, one-cycle pulse.
- o_busy  output  1  high from acceptance through the response cycle.

Behaviour:
- Clock, reset and interface: one clock, i_clk; reset is synchronous and active-high on i_reset. The polarity and synchronicity are fixed.
- Reset: FSM enters IDLE, wait counter = 0. o_wb_ack, o_wb_err, o_busy and o_wb_dat are all 0. RAM contents are not reset.
- FSM states:
  - IDLE: when i_wb_cyc & i_wb_stb, latch we/adr/dat/sel, evaluate legality and set the wait counter to WAIT_STATES. Go to WAIT if WAIT_STATES != 0, else to RESP.
  - WAIT: decrement the counter each cycle. When the counter reaches 1, go to RESP next cycle.
  - RESP: drive exactly one of o_wb_ack or o_wb_err for one cycle, then return to IDLE.
- Abort: if i_wb_cyc=0 in any WAIT cycle, go to IDLE next cycle. No write, no ack, no err.
- Timing: a request sampled in IDLE at edge N gives ack/err high in cycle N+1+WAIT_STATES.
- No pipelining: the responder never accepts a new request in the RESP cycle. Earliest next acceptance is the cycle after RESP, so back-to-back requests are spaced 2+WAIT_STATES cycles apart.
- Legality:
  - offset = i_wb_adr - BASE_ADDR (32-bit, unsigned).
  - Legal iff i_wb_adr >= BASE_ADDR, offset < DEPTH_WORDS*4 and i_wb_adr[1:0] == 2'b00.
  - Word index = offset[$clog2(DEPTH_WORDS)+1:2].
- Write: performed at the RESP edge, only to lanes with sel=1; other lanes keep their value. sel=4'b0000 writes nothing and still acks.
- Read: RAM word registered into o_wb_dat for the RESP cycle. All 32 bits are returned regardless of sel; the master extracts lanes.
- o_wb_dat is 0 in every non-ack cycle, including err cycles.
- Illegal access: err pulse instead of ack. No RAM write, o_wb_dat = 0.
- o_busy: 1 in WAIT and RESP, 0 in IDLE.
- o_wb_ack & o_wb_err are never high together.
- Reset during WAIT or RESP: the reset takes priority, nothing is written, outputs are 0 next cycle.
- Master deasserting stb (cyc held) during WAIT: the request already latched completes normally.

Test Plan:
- Reset, then write adr=0x10, dat=0xDEADBEEF, sel=4'hF with WAIT_STATES=2 -> ack high exactly 3 cycles after acceptance for one cycle. Read adr=0x10 -> o_wb_dat=0xDEADBEEF with ack.
- Word 0x10 = 0xDEADBEEF; write dat=0x11223344, sel=4'b0101 -> read returns 0xDE22BE44.
- Read adr=DEPTH_WORDS*4 (0x1000) and adr=0x13 -> err pulse, ack=0, o_wb_dat=0. A following read of 0x10 is unchanged.
- Write 0x0 = 0xAAAA5555, then drop cyc in the first WAIT cycle -> no ack/err, o_busy=0 next cycle. Read 0x0 returns the prior value.
- WAIT_STATES=0, stb held across three back-to-back reads -> acks every 2 cycles, each with correct data.
- Assert i_reset in a WAIT cycle of a write -> ack never pulses, o_busy=0 after reset, target word unchanged.
